// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: H/V counters, blank/sync flags, flipped
// counts and raster-line IRQs. Timing regs are double-buffered and swap at frame wrap.
module video_timing_gen #(
  parameter int unsigned H_W        = 10,
  parameter int unsigned V_W        = 9,
  parameter int unsigned NUM_IRQ    = 2,
  parameter int unsigned IRQ_HPOS   = 384,
  parameter int unsigned RST_HTOT   = 511,
  parameter int unsigned RST_HBLK_S = 384,
  parameter int unsigned RST_HBLK_E = 0,
  parameter int unsigned RST_HS_S   = 400,
  parameter int unsigned RST_HS_E   = 440,
  parameter int unsigned RST_VTOT   = 283,
  parameter int unsigned RST_VBLK_S = 256,
  parameter int unsigned RST_VBLK_E = 0,
  parameter int unsigned RST_VS_S   = 262,
  parameter int unsigned RST_VS_E   = 268
) (
  input  logic               CLK_32M,
  input  logic               RESET_N,
  input  logic               CE_PIX,
  input  logic               WR,
  input  logic [3:0]         ADDR,
  input  logic [15:0]        D,
  input  logic [NUM_IRQ-1:0] IRQ_ACK,
  output logic [H_W-1:0]     H,
  output logic [V_W-1:0]     V,
  output logic [H_W-1:0]     HE,
  output logic [V_W-1:0]     VE,
  output logic               HBLK,
  output logic               VBLK,
  output logic               CPBLK,
  output logic               HS_N,
  output logic               VS_N,
  output logic               LINE_END,
  output logic [NUM_IRQ-1:0] IRQ_PEND,
  output logic               IRQ,
  output logic [7:0]         FRAME_CNT
);

  // Index order in the H and V banks: TOT, BLK_S, BLK_E, S_S, S_E
  localparam logic [H_W-1:0] H_RST [5] = '{H_W'(RST_HTOT), H_W'(RST_HBLK_S),
    H_W'(RST_HBLK_E), H_W'(RST_HS_S), H_W'(RST_HS_E)};
  localparam logic [V_W-1:0] V_RST [5] = '{V_W'(RST_VTOT), V_W'(RST_VBLK_S),
    V_W'(RST_VBLK_E), V_W'(RST_VS_S), V_W'(RST_VS_E)};
  localparam logic [H_W-1:0] IRQ_H = H_W'(IRQ_HPOS);

  logic [H_W-1:0]     hl_q [5];
  logic [H_W-1:0]     ha_q [5];
  logic [V_W-1:0]     vl_q [5];
  logic [V_W-1:0]     va_q [5];
  logic               flip_q;
  logic [NUM_IRQ-1:0] irq_en_q;
  logic [V_W-1:0]     irq_line_q [NUM_IRQ];

  logic [H_W-1:0]     h_q, h_d;
  logic [V_W-1:0]     v_q, v_d;
  logic               hblk_q, hblk_d, hs_n_q, hs_n_d;
  logic               vblk_q, vblk_d, vs_n_q, vs_n_d;
  logic               line_end_q;
  logic [7:0]         frame_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d, irq_set;
  logic               line_wrap, frame_wrap;
  logic [V_W-1:0]     ve;
  logic               unused_bits;

  assign unused_bits = ^D;

  // Set/clear flag update; equal set and clear positions freeze the flag.
  function automatic logic flag_h(input logic cur, input logic [H_W-1:0] nxt,
                                  input logic [H_W-1:0] s, input logic [H_W-1:0] e);
    flag_h = cur;
    if (s != e) begin
      if (nxt == s)      flag_h = 1'b1;
      else if (nxt == e) flag_h = 1'b0;
    end
  endfunction

  function automatic logic flag_v(input logic cur, input logic [V_W-1:0] nxt,
                                  input logic [V_W-1:0] s, input logic [V_W-1:0] e);
    flag_v = cur;
    if (s != e) begin
      if (nxt == s)      flag_v = 1'b1;
      else if (nxt == e) flag_v = 1'b0;
    end
  endfunction

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      hl_q     <= H_RST;
      ha_q     <= H_RST;
      vl_q     <= V_RST;
      va_q     <= V_RST;
      flip_q   <= 1'b0;
      irq_en_q <= '0;
      for (int unsigned n = 0; n < NUM_IRQ; n++) irq_line_q[n] <= '0;
    end else begin
      if (WR) begin
        for (int unsigned i = 0; i < 5; i++) begin
          if (ADDR == 4'(i))     hl_q[i] <= D[H_W-1:0];
          if (ADDR == 4'(i + 5)) vl_q[i] <= D[V_W-1:0];
        end
        if (ADDR == 4'd10) begin
          flip_q   <= D[0];
          irq_en_q <= D[NUM_IRQ:1];
        end
        for (int unsigned n = 0; n < NUM_IRQ; n++)
          if (ADDR == 4'(12 + n)) irq_line_q[n] <= D[V_W-1:0];
      end
      if (CE_PIX && frame_wrap) begin
        ha_q <= hl_q;
        va_q <= vl_q;
      end
    end
  end

  // Counters past a shrunk TOT keep incrementing until they roll over naturally.
  always_comb begin
    line_wrap  = (h_q == ha_q[0]);
    frame_wrap = line_wrap && (v_q == va_q[0]);
    h_d        = line_wrap ? '0 : h_q + 1'b1;
    v_d        = v_q;
    if (line_wrap) v_d = (v_q == va_q[0]) ? '0 : v_q + 1'b1;
    hblk_d = flag_h(hblk_q, h_d, ha_q[1], ha_q[2]);
    hs_n_d = ~flag_h(~hs_n_q, h_d, ha_q[3], ha_q[4]);
    vblk_d = vblk_q;
    vs_n_d = vs_n_q;
    if (line_wrap) begin
      vblk_d = flag_v(vblk_q, v_d, va_q[1], va_q[2]);
      vs_n_d = ~flag_v(~vs_n_q, v_d, va_q[3], va_q[4]);
    end
  end

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      h_q        <= '0;
      v_q        <= '0;
      hblk_q     <= 1'b0;
      hs_n_q     <= 1'b1;
      vblk_q     <= 1'b0;
      vs_n_q     <= 1'b1;
      line_end_q <= 1'b0;
      frame_q    <= '0;
    end else begin
      line_end_q <= CE_PIX && line_wrap;
      if (CE_PIX) begin
        h_q    <= h_d;
        v_q    <= v_d;
        hblk_q <= hblk_d;
        hs_n_q <= hs_n_d;
        vblk_q <= vblk_d;
        vs_n_q <= vs_n_d;
        if (frame_wrap) frame_q <= frame_q + 8'd1;
      end
    end
  end

  assign ve = v_q ^ {V_W{flip_q}};

  always_comb begin
    irq_set = '0;
    for (int unsigned n = 0; n < NUM_IRQ; n++)
      irq_set[n] = CE_PIX && (h_q == IRQ_H) && (ve == irq_line_q[n]) && irq_en_q[n];
    pend_d = (pend_q & ~IRQ_ACK) | irq_set;
  end

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) pend_q <= '0;
    else          pend_q <= pend_d;
  end

  assign H         = h_q;
  assign V         = v_q;
  assign HE        = h_q ^ {H_W{flip_q}};
  assign VE        = ve;
  assign HBLK      = hblk_q;
  assign VBLK      = vblk_q;
  assign CPBLK     = hblk_q | vblk_q;
  assign HS_N      = hs_n_q;
  assign VS_N      = vs_n_q;
  assign LINE_END  = line_end_q;
  assign IRQ_PEND  = pend_q;
  assign IRQ       = |pend_q;
  assign FRAME_CNT = frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a scaled raster: 64 CE per line, 20 lines per frame.
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        RESET_N, CE_PIX, WR;
  logic [3:0]  ADDR;
  logic [15:0] D;
  logic [1:0]  IRQ_ACK;
  logic [9:0]  H, HE;
  logic [8:0]  V, VE;
  logic        HBLK, VBLK, CPBLK, HS_N, VS_N, LINE_END, IRQ;
  logic [1:0]  IRQ_PEND;
  logic [7:0]  FRAME_CNT;

  int errors = 0, checks = 0;
  int ce_gap = 4;
  int le_cnt, hblk_cnt, hs_cnt, vblk_cnt, vs_cnt, rise_cnt;
  int hblk_bad, hs_bad, vblk_bad, vs_bad;
  logic pend_prev = 1'b0;
  int n;

  video_timing_gen #(
    .H_W(10), .V_W(9), .NUM_IRQ(2), .IRQ_HPOS(40),
    .RST_HTOT(63), .RST_HBLK_S(48), .RST_HBLK_E(0), .RST_HS_S(52), .RST_HS_E(56),
    .RST_VTOT(19), .RST_VBLK_S(16), .RST_VBLK_E(0), .RST_VS_S(17), .RST_VS_E(18)
  ) dut (
    .CLK_32M(clk), .RESET_N(RESET_N), .CE_PIX(CE_PIX), .WR(WR), .ADDR(ADDR), .D(D),
    .IRQ_ACK(IRQ_ACK), .H(H), .V(V), .HE(HE), .VE(VE), .HBLK(HBLK), .VBLK(VBLK),
    .CPBLK(CPBLK), .HS_N(HS_N), .VS_N(VS_N), .LINE_END(LINE_END), .IRQ_PEND(IRQ_PEND),
    .IRQ(IRQ), .FRAME_CNT(FRAME_CNT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    WR = 1'b1; ADDR = a; D = d;
    tick();
    WR = 1'b0;
  endtask

  task automatic clr();
    le_cnt = 0; hblk_cnt = 0; hs_cnt = 0; vblk_cnt = 0; vs_cnt = 0; rise_cnt = 0;
    hblk_bad = 0; hs_bad = 0; vblk_bad = 0; vs_bad = 0;
  endtask

  task automatic step();
    CE_PIX = 1'b1;
    tick();
    CE_PIX = 1'b0;
    if (LINE_END) le_cnt++;
    if (HBLK) hblk_cnt++;
    if (!HS_N) hs_cnt++;
    if (VBLK) vblk_cnt++;
    if (!VS_N) vs_cnt++;
    if (HBLK != (H >= 10'd48)) hblk_bad++;
    if (!HS_N != (H >= 10'd52 && H <= 10'd55)) hs_bad++;
    if (VBLK != (V >= 9'd16)) vblk_bad++;
    if (!VS_N != (V == 9'd17)) vs_bad++;
    if (IRQ_PEND[0] && !pend_prev) rise_cnt++;
    pend_prev = IRQ_PEND[0];
    for (int i = 1; i < ce_gap; i++) tick();
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    RESET_N = 1'b1; CE_PIX = 1'b0; WR = 1'b0; ADDR = '0; D = '0; IRQ_ACK = '0;
    #2 RESET_N = 1'b0;
    tick(); tick();
    chk("rst_h", H, 0);          chk("rst_v", V, 0);
    chk("rst_he", HE, 0);        chk("rst_ve", VE, 0);
    chk("rst_hblk", HBLK, 0);    chk("rst_vblk", VBLK, 0);
    chk("rst_hs_n", HS_N, 1);    chk("rst_vs_n", VS_N, 1);
    chk("rst_le", LINE_END, 0);  chk("rst_pend", IRQ_PEND, 0);
    chk("rst_frame", FRAME_CNT, 0);
    RESET_N = 1'b1;

    // Two frames of default timing, one CE every fourth clock
    clr();
    steps(1280);
    chk("f1_frame", FRAME_CNT, 1); chk("f1_h", H, 0); chk("f1_v", V, 0);
    chk("f1_line_ends", le_cnt, 20);
    chk("f1_hblk_cnt", hblk_cnt, 320); chk("f1_hs_cnt", hs_cnt, 80);
    chk("f1_vblk_cnt", vblk_cnt, 256); chk("f1_vs_cnt", vs_cnt, 64);
    steps(1280);
    chk("f2_frame", FRAME_CNT, 2);
    chk("hblk_window", hblk_bad, 0); chk("hs_window", hs_bad, 0);
    chk("vblk_window", vblk_bad, 0); chk("vs_window", vs_bad, 0);
    ce_gap = 1;

    // Raster IRQ on line 10, no flip
    wr(4'd12, 16'd10);
    wr(4'd10, 16'h0002);
    n = 0;
    while (!IRQ_PEND[0] && n < 2000) begin step(); n++; end
    chk("irq_steps", n, 681); chk("irq_v", V, 10); chk("irq_h", H, 41);
    chk("irq_out", IRQ, 1);

    // Ack coinciding with a fresh set: set wins; a lone ack clears
    n = 0;
    while (!(H == 10'd40 && V == 9'd10) && n < 2000) begin step(); n++; end
    chk("to_irq_pos", n, 1279);
    IRQ_ACK = 2'b01; CE_PIX = 1'b1;
    tick();
    CE_PIX = 1'b0;
    chk("ack_vs_set", IRQ_PEND[0], 1);
    tick();
    IRQ_ACK = 2'b00;
    chk("ack_clear", IRQ_PEND[0], 0); chk("ack_irq", IRQ, 0);
    pend_prev = 1'b0;

    // Flip: VE=10 needs V=501, which this raster never reaches
    wr(4'd10, 16'h0003);
    clr();
    steps(1280);
    chk("flip_rises", rise_cnt, 0); chk("flip_pend", IRQ_PEND[0], 0);
    chk("flip_h", H, 41); chk("flip_v", V, 10);
    chk("flip_he", HE, 982); chk("flip_ve", VE, 501);
    wr(4'd12, 16'd501);
    n = 0;
    while (!IRQ_PEND[0] && n < 2000) begin step(); n++; end
    chk("flip_irq_steps", n, 1280); chk("flip_irq_v", V, 10);
    wr(4'd10, 16'h0000);
    chk("disable_keeps", IRQ_PEND[0], 1);
    IRQ_ACK = 2'b01; tick(); IRQ_ACK = 2'b00;
    chk("ack2_clear", IRQ_PEND[0], 0);

    // HTOT shrink mid-frame takes effect only at the frame wrap
    wr(4'd0, 16'd47);
    n = 0;
    while (!(H == 10'd0 && V == 9'd11) && n < 2000) begin step(); n++; end
    chk("old_line_tail", n, 23);
    n = 0;
    while (!(H == 10'd0 && V == 9'd0) && n < 2000) begin step(); n++; end
    chk("old_to_wrap", n, 576); chk("frame6", FRAME_CNT, 6);
    wr(4'd0, 16'd63); wr(4'd1, 16'd40); wr(4'd2, 16'd5);
    clr();
    steps(48);
    chk("short_line_h", H, 0); chk("short_line_v", V, 1); chk("short_le", le_cnt, 1);
    steps(912);
    chk("short_frame_h", H, 0); chk("short_frame_v", V, 0);
    chk("short_le_frame", le_cnt, 20); chk("frame7", FRAME_CNT, 7);
    chk("short_hblk", HBLK, 0);

    // HBLK 40..4 window, then S==E freezes it high
    steps(41);
    chk("hblk_set40", HBLK, 1);
    steps(28);
    chk("hblk_clr5_h", H, 5); chk("hblk_clr5", HBLK, 0);
    wr(4'd1, 16'd50); wr(4'd2, 16'd50);
    steps(1211);
    chk("frame8", FRAME_CNT, 8); chk("wrap_hblk", HBLK, 1);
    clr();
    steps(64);
    chk("hblk_frozen", hblk_cnt, 64); chk("frozen_v", V, 1);

    // Async reset mid-line
    steps(10);
    chk("pre_rst_hblk", HBLK, 1);
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_h", H, 0);           chk("arst_v", V, 0);
    chk("arst_hblk", HBLK, 0);     chk("arst_hs_n", HS_N, 1);
    chk("arst_vs_n", VS_N, 1);     chk("arst_frame", FRAME_CNT, 0);
    tick();
    RESET_N = 1'b1;
    step();
    chk("post_rst_h", H, 1); chk("post_rst_v", V, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
